// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one 4-bit ALU among NUM_REQ requesters
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [3:0]      a_q;
  logic [3:0]      b_q;
  logic [2:0]      op_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] scan_id;
  int              scan_idx;

  logic [7:0]      a8;
  logic [7:0]      b8;
  logic [7:0]      alu_data;
  logic            alu_err;

  // Scan starts one past the last winner so the previous owner is considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    scan_id     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_id = ID_W'(scan_idx);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign req_ready = (state == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy      = (state != S_IDLE);

  always_comb begin
    a8       = {4'b0000, a_q};
    b8       = {4'b0000, b_q};
    alu_data = 8'h00;
    alu_err  = 1'b0;
    case (op_q)
      3'b000: alu_data = a8 + b8;
      3'b001: alu_data = a8 - b8;
      3'b010: alu_data = a8 * b8;
      3'b011: begin
        if (b_q == 4'd0) begin
          alu_data = 8'hFF;
          alu_err  = 1'b1;
        end else begin
          alu_data = a8 / b8;
        end
      end
      3'b100: alu_data = a8 & b8;
      3'b101: alu_data = a8 | b8;
      default: begin
        alu_data = 8'h00;
        alu_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            a_q    <= req_a[4*grant_id +: 4];
            b_q    <= req_b[4*grant_id +: 4];
            op_q   <= req_op[3*grant_id +: 3];
            rsp_id <= grant_id;
            rr_ptr <= grant_id;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_data;
          rsp_err   <= alu_err;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_count != {CNT_W{1'b1}}) op_count <= op_count + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
